game_sequencer: RTL

- Top-level game-flow controller for the frog game: attract/start, play, death, level-up and game-over.
- Gates player and car motion, owns lives, score and level.
- Derives a per-frame tick from VGA_VS, so all timed phases are counted in display frames.
- Sits between vga_control, player_control, car_control and the LED/7-segment outputs.

---
 rtl/game_sequencer_pkg.sv | 26 ++
 rtl/game_sequencer_if.sv | 29 ++
 rtl/game_sequencer_bcd_score_counter.sv | 41 ++++
 rtl/game_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared state codes, default game parameters and field widths for the frog game flow.
package game_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LEVEL_W = 4;

  localparam int unsigned DEF_MAX_LIVES    = 4;
  localparam int unsigned DEF_DEATH_FRAMES = 90;
  localparam int unsigned DEF_WIN_FRAMES   = 60;
  localparam int unsigned DEF_MAX_LEVEL    = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_ATTRACT   = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // Thermometer lives display; four or more lives light every LED.
  function automatic logic [3:0] lives_to_led(input logic [2:0] lives);
    if (lives >= 3'd4) return '1;
    return 4'((4'd1 << lives) - 4'd1);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and the surrounding frog-game blocks.
interface game_sequencer_if;
  import game_sequencer_pkg::*;

  logic               VGA_VS;
  logic               start_req;
  logic               collision;
  logic               goal_reached;
  logic [STATE_W-1:0] game_state;
  logic               player_enable;
  logic               car_enable;
  logic               player_reset;
  logic [LEVEL_W-1:0] level;
  logic [7:0]         score_bcd;
  logic [3:0]         lives_led;
  logic               blink;

  modport master (
    output VGA_VS, start_req, collision, goal_reached,
    input  game_state, player_enable, car_enable, player_reset,
           level, score_bcd, lives_led, blink
  );

  modport slave (
    input  VGA_VS, start_req, collision, goal_reached,
    output game_state, player_enable, car_enable, player_reset,
           level, score_bcd, lives_led, blink
  );
endinterface

// File: rtl/game_sequencer_bcd_score_counter.sv
// Two-digit BCD score counter with clear, increment and hold at 99.
module bcd_score_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] score_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr_i) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc_i && !(tens_q == 4'd9 && units_q == 4'd9)) begin
      if (units_q == 4'd9) begin
        units_d = '0;
        tens_d  = tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign score_o = {tens_q, units_q};

endmodule

// File: rtl/game_sequencer.sv
// Frog game flow controller: attract, play, death, level-up and game-over, timed in display frames.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LIVES    = DEF_MAX_LIVES,
  parameter int unsigned DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int unsigned WIN_FRAMES   = DEF_WIN_FRAMES,
  parameter int unsigned MAX_LEVEL    = DEF_MAX_LEVEL
) (
  input logic             CLK,
  input logic             RST_N,
  game_sequencer_if.slave bus
);

  localparam logic [2:0]         LIVES_INIT = 3'(MAX_LIVES);
  localparam logic [7:0]         DEATH_T    = 8'(DEATH_FRAMES);
  localparam logic [7:0]         WIN_T      = 8'(WIN_FRAMES);
  localparam logic [LEVEL_W-1:0] LEVEL_SAT  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);

  state_t             state_q, state_d;
  logic               vs_q, start_q;
  logic [2:0]         lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [7:0]         timer_q, timer_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic               pen_q, pen_d, cen_q, cen_d;
  logic               prst_q, prst_d, blink_q, blink_d;
  logic               score_inc, score_clr;
  logic [7:0]         score_bcd;

  logic frame_tick, start_edge;
  assign frame_tick = vs_q & ~bus.VGA_VS;
  assign start_edge = bus.start_req & ~start_q;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    timer_d   = timer_q;
    fcnt_d    = fcnt_q;
    prst_d    = 1'b0;
    score_inc = 1'b0;
    score_clr = 1'b0;
    case (state_q)
      ST_ATTRACT, ST_GAME_OVER: begin
        if (start_edge) begin
          state_d   = ST_PLAY;
          lives_d   = LIVES_INIT;
          level_d   = LEVEL_ONE;
          timer_d   = '0;
          score_clr = 1'b1;
          prst_d    = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bus.collision) begin
          state_d = ST_DYING;
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
          timer_d = DEATH_T;
          fcnt_d  = '0;
        end else if (bus.goal_reached) begin
          state_d   = ST_LEVEL_UP;
          score_inc = 1'b1;
          if (level_q < LEVEL_SAT) level_d = level_q + LEVEL_ONE;
          timer_d   = WIN_T;
        end
      end
      ST_DYING: begin
        // Timer reaches zero on the exit tick, so the phase lasts exactly DEATH_FRAMES ticks.
        if (frame_tick) begin
          fcnt_d = fcnt_q + 4'd1;
          if (timer_q <= 8'd1) begin
            timer_d = '0;
            if (lives_q == 3'd0) begin
              state_d = ST_GAME_OVER;
            end else begin
              state_d = ST_PLAY;
              prst_d  = 1'b1;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      ST_LEVEL_UP: begin
        if (frame_tick) begin
          if (timer_q <= 8'd1) begin
            timer_d = '0;
            state_d = ST_PLAY;
            prst_d  = 1'b1;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: state_d = ST_ATTRACT;
    endcase
    pen_d   = (state_d == ST_PLAY);
    cen_d   = (state_d == ST_PLAY);
    blink_d = (state_d == ST_DYING) & fcnt_d[3];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_ATTRACT;
      vs_q    <= 1'b1;
      start_q <= 1'b1;
      lives_q <= LIVES_INIT;
      level_q <= LEVEL_ONE;
      timer_q <= '0;
      fcnt_q  <= '0;
      pen_q   <= 1'b0;
      cen_q   <= 1'b0;
      prst_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= bus.VGA_VS;
      start_q <= bus.start_req;
      lives_q <= lives_d;
      level_q <= level_d;
      timer_q <= timer_d;
      fcnt_q  <= fcnt_d;
      pen_q   <= pen_d;
      cen_q   <= cen_d;
      prst_q  <= prst_d;
      blink_q <= blink_d;
    end
  end

  bcd_score_counter u_score (
    .clk     (CLK),
    .rst_n   (RST_N),
    .inc_i   (score_inc),
    .clr_i   (score_clr),
    .score_o (score_bcd)
  );

  assign bus.game_state    = state_q;
  assign bus.player_enable = pen_q;
  assign bus.car_enable    = cen_q;
  assign bus.player_reset  = prst_q;
  assign bus.level         = level_q;
  assign bus.score_bcd     = score_bcd;
  assign bus.lives_led     = lives_to_led(lives_q);
  assign bus.blink         = blink_q;

endmodule
